// File: rtl/row_seq_pkg.sv
// row_seq_pkg
// Shared definitions for the row-buffer sequencer slice:
//   state_t     sequencer states (IDLE, RUN, FLUSH)
//   ASEL_INIT   one-hot write-row select used after reset and on every sof
//   asel_index  one-hot row select -> row index (0-4)
//   asel_rotate one-hot row select rotated left by one row, bit 4 wraps to bit 0
package row_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] ASEL_INIT = 5'b00001;

  function automatic logic [2:0] asel_index(input logic [4:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (sel[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [4:0] asel_rotate(input logic [4:0] sel);
    return {sel[3:0], sel[4]};
  endfunction

endpackage

// File: rtl/row_buffer_sequencer_if.sv
// row_buffer_sequencer_if
// Bundles the pixel-source handshake and the five-row array drive of the
// row-buffer sequencer.
//   source side : din, validin, sof (to sequencer), ready (from sequencer)
//   array side  : ram_din, ram_ce, asel, newest, col, row, win_valid, eof
// Modports:
//   master - the pixel source / observer (drives din/validin/sof)
//   slave  - the sequencer itself
interface row_buffer_sequencer_if #(
  parameter int WIDTH  = 420,
  parameter int HEIGHT = 240
);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT + 2);

  logic [7:0]       din;
  logic             validin;
  logic             sof;
  logic             ready;
  logic [7:0]       ram_din;
  logic             ram_ce;
  logic [4:0]       asel;
  logic [2:0]       newest;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             win_valid;
  logic             eof;

  modport master (
    output din, validin, sof,
    input  ready, ram_din, ram_ce, asel, newest, col, row, win_valid, eof
  );

  modport slave (
    input  din, validin, sof,
    output ready, ram_din, ram_ce, asel, newest, col, row, win_valid, eof
  );

endinterface

// File: rtl/row_seq_counter.sv
// row_seq_counter
// Column/row position counter. Holds the position of the next beat to be
// written. col wraps to 0 after WIDTH-1 and row advances on that wrap.
//   clock, reset_n : clock, synchronous active-low reset
//   clear          : restart at (0,0); combined with inc the counter lands on
//                    the position after (0,0) in the same cycle
//   inc            : advance one beat
//   col, row       : current position
//   last_col       : current col is WIDTH-1
module row_seq_counter #(
  parameter int WIDTH = 420,
  parameter int COL_W = $clog2(WIDTH),
  parameter int ROW_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_col
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  logic [COL_W-1:0] col_reg, col_next, col_base;
  logic [ROW_W-1:0] row_reg, row_next, row_base;

  always_comb begin
    col_base = clear ? '0 : col_reg;
    row_base = clear ? '0 : row_reg;
    col_next = col_base;
    row_next = row_base;
    if (inc) begin
      if (col_base == LAST_COL) begin
        col_next = '0;
        row_next = row_base + ROW_W'(1);
      end else begin
        col_next = col_base + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  assign col      = col_reg;
  assign row      = row_reg;
  assign last_col = (col_reg == LAST_COL);

endmodule

// File: rtl/row_buffer_sequencer.sv
// row_buffer_sequencer
// Sequences the five-row line-buffer array feeding a 5x5 window stage.
// Accepts the pixel stream, tracks column/row, drives the array's one-hot
// row select, shift enable and data, and tags each written beat with
// window-valid, newest-row and end-of-frame information.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      row_buffer_sequencer_if.slave (source handshake + array drive)
// Build option:
//   ROW_BUFFER_SEQUENCER_FLUSH_EN - append two zero lines after each frame
//   (FLUSH state, ready low while flushing, eof on the last flush beat).
//   Undefined: no FLUSH state, ready is constant 1, eof on the last pixel.
module row_buffer_sequencer
  import row_seq_pkg::*;
#(
  parameter int WIDTH  = 420,
  parameter int HEIGHT = 240
) (
  input  logic                   clock,
  input  logic                   reset_n,
  row_buffer_sequencer_if.slave  bus
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT + 2);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
`ifdef ROW_BUFFER_SEQUENCER_FLUSH_EN
  localparam logic [ROW_W-1:0] FLUSH_LAST_ROW = ROW_W'(HEIGHT + 1);
`endif

  state_t state_reg, state_next;

  // Position of the next beat to write (shared by RUN and FLUSH).
  logic [COL_W-1:0] pos_col;
  logic [ROW_W-1:0] pos_row;
  logic             pos_last;

  // Row select for the next beat; the output register carries the beat's own.
  logic [4:0] sel_reg;

  logic       ready_int;
  logic       accept;
  logic       beat;
  logic       sof_beat;
  logic       eof_beat;
`ifdef ROW_BUFFER_SEQUENCER_FLUSH_EN
  logic       flush_beat;
`endif

  logic [COL_W-1:0] beat_col;
  logic [ROW_W-1:0] beat_row;
  logic [4:0]       beat_asel;
  logic             beat_last;
  logic [7:0]       beat_din;

  logic [7:0]       ram_din_reg;
  logic             ram_ce_reg;
  logic [4:0]       asel_reg;
  logic [2:0]       newest_reg;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic             win_valid_reg;
  logic             eof_reg;

`ifdef ROW_BUFFER_SEQUENCER_FLUSH_EN
  assign ready_int = (state_reg != FLUSH);
`else
  assign ready_int = 1'b1;
`endif

  assign accept = bus.validin & ready_int;

  always_comb begin
    state_next = state_reg;
    beat       = 1'b0;
    sof_beat   = 1'b0;
    eof_beat   = 1'b0;
`ifdef ROW_BUFFER_SEQUENCER_FLUSH_EN
    flush_beat = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        // Without sof the pixel is consumed and dropped.
        if (accept && bus.sof) begin
          beat       = 1'b1;
          sof_beat   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          beat = 1'b1;
          if (bus.sof) begin
            // Restart: the partial frame is abandoned without eof.
            sof_beat = 1'b1;
          end else if (pos_last && (pos_row == LAST_ROW)) begin
`ifdef ROW_BUFFER_SEQUENCER_FLUSH_EN
            state_next = FLUSH;
`else
            state_next = IDLE;
            eof_beat   = 1'b1;
`endif
          end
        end
      end
`ifdef ROW_BUFFER_SEQUENCER_FLUSH_EN
      FLUSH: begin
        // The counter simply continues into rows HEIGHT and HEIGHT+1.
        beat       = 1'b1;
        flush_beat = 1'b1;
        if (pos_last && (pos_row == FLUSH_LAST_ROW)) begin
          state_next = IDLE;
          eof_beat   = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  row_seq_counter #(
    .WIDTH (WIDTH),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (sof_beat),
    .inc      (beat),
    .col      (pos_col),
    .row      (pos_row),
    .last_col (pos_last)
  );

  // An sof beat is always written at (0,0) with the initial row select.
  assign beat_col  = sof_beat ? '0 : pos_col;
  assign beat_row  = sof_beat ? '0 : pos_row;
  assign beat_asel = sof_beat ? ASEL_INIT : sel_reg;
  assign beat_last = ~sof_beat & pos_last;

`ifdef ROW_BUFFER_SEQUENCER_FLUSH_EN
  assign beat_din = flush_beat ? 8'd0 : bus.din;
`else
  assign beat_din = bus.din;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      sel_reg       <= ASEL_INIT;
      ram_din_reg   <= 8'd0;
      ram_ce_reg    <= 1'b0;
      asel_reg      <= ASEL_INIT;
      newest_reg    <= 3'd0;
      col_reg       <= '0;
      row_reg       <= '0;
      win_valid_reg <= 1'b0;
      eof_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (beat) begin
        // Rotation takes effect on the beat after the last column.
        sel_reg       <= beat_last ? asel_rotate(beat_asel) : beat_asel;
        ram_din_reg   <= beat_din;
        ram_ce_reg    <= 1'b1;
        asel_reg      <= beat_asel;
        newest_reg    <= asel_index(beat_asel);
        col_reg       <= beat_col;
        row_reg       <= beat_row;
        win_valid_reg <= (beat_row >= ROW_W'(4)) && (beat_col >= COL_W'(4));
        eof_reg       <= eof_beat;
      end else begin
        // Position/data outputs hold; strobes drop.
        ram_ce_reg    <= 1'b0;
        win_valid_reg <= 1'b0;
        eof_reg       <= 1'b0;
      end
    end
  end

  assign bus.ready     = ready_int;
  assign bus.ram_din   = ram_din_reg;
  assign bus.ram_ce    = ram_ce_reg;
  assign bus.asel      = asel_reg;
  assign bus.newest    = newest_reg;
  assign bus.col       = col_reg;
  assign bus.row       = row_reg;
  assign bus.win_valid = win_valid_reg;
  assign bus.eof       = eof_reg;

endmodule

// File: tb/tb_row_buffer_sequencer.sv
// tb_row_buffer_sequencer
// Self-checking bench for row_buffer_sequencer with WIDTH=8, HEIGHT=6.
// Follows ROW_BUFFER_SEQUENCER_FLUSH_EN the same way as the design.
// The reference model tracks a linear beat index within the frame and
// derives col/row/asel/window/eof from it arithmetically.
module tb_row_buffer_sequencer;

  localparam int W = 8;
  localparam int H = 6;
`ifdef ROW_BUFFER_SEQUENCER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif
  localparam int REAL  = W * H;
  localparam int TOTAL = REAL + (FLUSH_EN ? 2 * W : 0);

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  row_buffer_sequencer_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  row_buffer_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0] ram_din;
    logic       ram_ce;
    logic [4:0] asel;
    logic [2:0] newest;
    logic [2:0] col;
    logic [2:0] row;
    logic       win_valid;
    logic       eof;
  } obs_t;

  typedef struct {
    logic [7:0] din;
    logic       v;
    logic       s;
    logic       e_ce;
    logic [7:0] e_din;
    logic [2:0] e_col;
    logic [2:0] e_row;
    logic [4:0] e_asel;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   ready_low = 0;
  int   m_mode;       // 0 idle, 1 run, 2 flush
  int   m_k;          // index of the next beat within the frame
  obs_t m_exp;

  function automatic obs_t sample();
    obs_t o;
    o.ram_din   = bus.ram_din;
    o.ram_ce    = bus.ram_ce;
    o.asel      = bus.asel;
    o.newest    = bus.newest;
    o.col       = bus.col;
    o.row       = bus.row;
    o.win_valid = bus.win_valid;
    o.eof       = bus.eof;
    return o;
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_obs(input string name);
    obs_t a;
    a = sample();
    checks++;
    if (a !== m_exp) begin
      errors++;
      $display("FAIL %s: got din=%h ce=%b asel=%b new=%0d col=%0d row=%0d win=%b eof=%b expected din=%h ce=%b asel=%b new=%0d col=%0d row=%0d win=%b eof=%b",
               name, a.ram_din, a.ram_ce, a.asel, a.newest, a.col, a.row, a.win_valid, a.eof,
               m_exp.ram_din, m_exp.ram_ce, m_exp.asel, m_exp.newest, m_exp.col, m_exp.row,
               m_exp.win_valid, m_exp.eof);
    end
  endtask

  task automatic model_reset();
    m_mode     = 0;
    m_k        = 0;
    m_exp      = '0;
    m_exp.asel = 5'b00001;
  endtask

  task automatic model_beat(input int k, input logic [7:0] d);
    int c, r;
    c = k % W;
    r = k / W;
    m_exp.ram_din   = d;
    m_exp.ram_ce    = 1'b1;
    m_exp.col       = 3'(c);
    m_exp.row       = 3'(r);
    m_exp.asel      = 5'(1 << (r % 5));
    m_exp.newest    = 3'(r % 5);
    m_exp.win_valid = (c >= 4) && (r >= 4);
    m_exp.eof       = (k == TOTAL - 1);
  endtask

  task automatic model_step(input logic [7:0] d, input logic v, input logic s);
    m_exp.ram_ce    = 1'b0;
    m_exp.win_valid = 1'b0;
    m_exp.eof       = 1'b0;
    if (m_mode == 2) begin
      model_beat(m_k, 8'd0);
      m_k++;
      if (m_k == TOTAL) m_mode = 0;
    end else if (v && s) begin
      model_beat(0, d);
      m_k    = 1;
      m_mode = 1;
    end else if (v && m_mode == 1) begin
      model_beat(m_k, d);
      m_k++;
      if (m_k == REAL) m_mode = FLUSH_EN ? 2 : 0;
    end
  endtask

  // One clock of stimulus: drive at negedge, check outputs 1 time unit after
  // the following posedge.
  task automatic step(input logic [7:0] d, input logic v, input logic s, input string name);
    @(negedge clock);
    bus.din     = d;
    bus.validin = v;
    bus.sof     = s;
    check_val({name, "_ready"}, int'(bus.ready), (m_mode != 2) ? 1 : 0);
    if (!bus.ready) ready_low++;
    model_step(d, v, s);
    @(posedge clock);
    #1;
    check_obs(name);
  endtask

  task automatic do_reset(input logic v);
    @(negedge clock);
    reset_n     = 1'b0;
    bus.validin = v;
    bus.sof     = 1'b0;
    bus.din     = 8'($urandom);
    @(posedge clock);
    #1;
    model_reset();
    check_obs("reset");
    check_val("reset_ready", int'(bus.ready), 1);
    reset_n = 1'b1;
  endtask

  vec_t vecs[17];
  int   beats, wins, eof_at, line;
  logic [4:0] line_asel[8];
  int   exp_line_asel[8];

  initial begin
    vecs[0]  = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 5'b00001};
    vecs[1]  = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 5'b00001};
    vecs[2]  = '{8'hA0, 1'b1, 1'b1, 1'b1, 8'hA0, 3'd0, 3'd0, 5'b00001};
    vecs[3]  = '{8'h33, 1'b0, 1'b0, 1'b0, 8'hA0, 3'd0, 3'd0, 5'b00001};
    vecs[4]  = '{8'hA1, 1'b1, 1'b0, 1'b1, 8'hA1, 3'd1, 3'd0, 5'b00001};
    vecs[5]  = '{8'h34, 1'b0, 1'b0, 1'b0, 8'hA1, 3'd1, 3'd0, 5'b00001};
    vecs[6]  = '{8'hA2, 1'b1, 1'b0, 1'b1, 8'hA2, 3'd2, 3'd0, 5'b00001};
    vecs[7]  = '{8'hA3, 1'b1, 1'b0, 1'b1, 8'hA3, 3'd3, 3'd0, 5'b00001};
    vecs[8]  = '{8'h35, 1'b0, 1'b0, 1'b0, 8'hA3, 3'd3, 3'd0, 5'b00001};
    vecs[9]  = '{8'hA4, 1'b1, 1'b0, 1'b1, 8'hA4, 3'd4, 3'd0, 5'b00001};
    vecs[10] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 3'd5, 3'd0, 5'b00001};
    vecs[11] = '{8'hA6, 1'b1, 1'b0, 1'b1, 8'hA6, 3'd6, 3'd0, 5'b00001};
    vecs[12] = '{8'h36, 1'b0, 1'b0, 1'b0, 8'hA6, 3'd6, 3'd0, 5'b00001};
    vecs[13] = '{8'hA7, 1'b1, 1'b0, 1'b1, 8'hA7, 3'd7, 3'd0, 5'b00001};
    vecs[14] = '{8'hB0, 1'b1, 1'b0, 1'b1, 8'hB0, 3'd0, 3'd1, 5'b00010};
    vecs[15] = '{8'h37, 1'b0, 1'b0, 1'b0, 8'hB0, 3'd0, 3'd1, 5'b00010};
    vecs[16] = '{8'hB1, 1'b1, 1'b0, 1'b1, 8'hB1, 3'd1, 3'd1, 5'b00010};
    exp_line_asel = '{1, 2, 4, 8, 16, 1, 2, 4};

    reset_n     = 1'b0;
    bus.din     = 8'd0;
    bus.validin = 1'b0;
    bus.sof     = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);

    // Table: IDLE discard, then validin toggling in RUN across a line end.
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].din, vecs[i].v, vecs[i].s, "vec_model");
      checks++;
      if ({bus.ram_ce, bus.ram_din, bus.col, bus.row, bus.asel} !==
          {vecs[i].e_ce, vecs[i].e_din, vecs[i].e_col, vecs[i].e_row, vecs[i].e_asel}) begin
        errors++;
        $display("FAIL vec%0d: got ce=%b din=%h col=%0d row=%0d asel=%b expected ce=%b din=%h col=%0d row=%0d asel=%b",
                 i, bus.ram_ce, bus.ram_din, bus.col, bus.row, bus.asel,
                 vecs[i].e_ce, vecs[i].e_din, vecs[i].e_col, vecs[i].e_row, vecs[i].e_asel);
      end
      $display("vec %0d din=%h v=%b sof=%b -> ce=%b din=%h col=%0d row=%0d asel=%b",
               i, vecs[i].din, vecs[i].v, vecs[i].s, bus.ram_ce, bus.ram_din,
               bus.col, bus.row, bus.asel);
    end

    // Full frame with continuous validin, sof on the first pixel.
    do_reset(1'b0);
    beats = 0; wins = 0; eof_at = -1; line = 0; ready_low = 0;
    for (int i = 0; i < TOTAL + 2; i++) begin
      step(8'(i + 1), 1'b1, (i == 0), "frame");
      if (bus.ram_ce) begin
        beats++;
        if (bus.win_valid) wins++;
        if (bus.eof) eof_at = beats;
        if (bus.col == 3'd0 && line < 8) begin
          line_asel[line] = bus.asel;
          line++;
        end
      end
    end
    $display("frame beats=%0d wins=%0d eof_at=%0d ready_low=%0d", beats, wins, eof_at, ready_low);
    check_val("frame_beats", beats, TOTAL);
    check_val("frame_eof_beat", eof_at, TOTAL);
    check_val("frame_win_count", wins, FLUSH_EN ? 16 : 8);
    check_val("frame_ready_low", ready_low, FLUSH_EN ? 2 * W : 0);
    check_val("frame_lines", line, TOTAL / W);
    for (int li = 0; li < TOTAL / W; li++) begin
      check_val("frame_line_asel", int'(line_asel[li]), exp_line_asel[li]);
    end

    // sof re-asserted at row 2, col 3.
    do_reset(1'b0);
    for (int i = 0; i < 19; i++) step(8'($urandom), 1'b1, (i == 0), "restart_pre");
    step(8'h5A, 1'b1, 1'b1, "restart");
    $display("restart ce=%b col=%0d row=%0d asel=%b eof=%b", bus.ram_ce, bus.col, bus.row, bus.asel, bus.eof);
    check_val("restart_pos", int'({bus.ram_ce, bus.col, bus.row, bus.asel, bus.eof}),
              int'({1'b1, 3'd0, 3'd0, 5'b00001, 1'b0}));
    for (int i = 0; i < 10; i++) step(8'($urandom), 1'b1, 1'b0, "restart_post");

    // Reset during row 3, then pixels without sof are ignored.
    do_reset(1'b0);
    for (int i = 0; i < 28; i++) step(8'($urandom), 1'b1, (i == 0), "midreset_pre");
    do_reset(1'b1);
    $display("midreset ce=%b col=%0d row=%0d asel=%b", bus.ram_ce, bus.col, bus.row, bus.asel);
    for (int i = 0; i < 5; i++) begin
      step(8'($urandom), 1'b1, 1'b0, "midreset_ignore");
      check_val("midreset_no_ce", int'(bus.ram_ce), 0);
    end
    step(8'hC3, 1'b1, 1'b1, "midreset_sof");

    // Randomized traffic against the model.
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        step(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0), "random");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_buffer_sequencer.md
# row_buffer_sequencer

Sequences the five-row line-buffer array feeding the 5x5 window stage. It accepts the raw pixel stream and tracks column and row position. It drives the array's one-hot row-select, clock-enable and data inputs, rotating the write row at every line end, and tags each written beat with window-valid and newest-row information for the downstream 5x5 kernel. It sits between the pixel source and the five-row array.

## Interface
- WIDTH, 420: pixels per line; must match the array depth (420 or 210).
- HEIGHT, 240: lines per frame, 5 or more.
- clock  in  1  rising-edge clock for everything.
- reset_n  in  1  synchronous, active-low reset.
- din  in  8  pixel from source.
- validin  in  1  din valid.
- sof  in  1  start of frame; qualified by validin; marks the first pixel of a frame.
- ready  out  1  block accepts din this cycle.
- ram_din  out  8  data to array din.
- ram_ce  out  1  array shift enable (the array's validin).
- asel  out  5  one-hot write-row select.
- newest  out  3  index (0-4) of the array row holding the newest line for this beat.
- col  out  clog2(WIDTH)  column of the current ram_ce beat.
- row  out  clog2(HEIGHT+2)  line of the current ram_ce beat.
- win_valid  out  1  the current beat completes a full 5x5 window.
- eof  out  1  one-cycle pulse on the last beat of a frame, including flush.

## Operation
- Accept condition: validin & ready.
- ready is 1 in IDLE and RUN and 0 in FLUSH.
- States:
  - IDLE: discard accepted pixels without sof. An accepted pixel with sof is written as col 0, row 0, and the state goes to RUN.
  - RUN: each accepted pixel is written at (col, row). col increments and wraps to 0 at WIDTH-1; row increments on that wrap. If the beat at row HEIGHT-1, col WIDTH-1 is accepted, go to FLUSH (macro defined) or IDLE.
  - FLUSH: issue 2*WIDTH beats on consecutive cycles with ram_din=0 and ram_ce=1, rows HEIGHT and HEIGHT+1. Then go to IDLE.
- asel:
  - Reset value is 5'b00001.
  - Rotates left (bit 4 wraps to bit 0) when the beat at col WIDTH-1 is written.
  - Reloads 5'b00001 on every sof-accepted beat.
- newest is the index of the set bit of asel for the same beat.
- win_valid = ram_ce & (row >= 4) & (col >= 4).
- sof accepted in RUN: restarts the frame. col=0, row=0, asel=00001, and the beat is written. The partial frame is abandoned with no eof.
- sof is ignored in FLUSH, because ready=0.
- eof is asserted on the final beat of a frame: the last RUN beat without the macro, the last FLUSH beat with it.
- Reset mid-frame: all counters clear and the state returns to IDLE.

## Timing
- All outputs except ready are registered. An accepted pixel in cycle N appears on ram_din/ram_ce/asel/newest/col/row/win_valid/eof in cycle N+1.
- ready is combinational from state only; it has no dependence on validin.
- Throughput is one pixel per cycle with no bubbles at line or frame boundaries.
- Every rotation happens in the cycle after the last-column beat. The first pixel of the next line is therefore written with the new asel with no gap.
- Reset values: ready=1 (IDLE), ram_din=0, ram_ce=0, asel=5'b00001, newest=0, col=0, row=0, win_valid=0, eof=0.
- No output is X after reset.

## Configuration
- ROW_BUFFER_SEQUENCER_FLUSH_EN defined:
  - FLUSH state is present.
  - Two zero lines are appended per frame, so the bottom two image rows get windows.
  - eof is on the last flush beat.
- Macro undefined:
  - FLUSH state and its counter are removed.
  - ready is a constant 1.
  - The frame ends at the last real pixel, with eof there.

## Structure
- Package row_seq_pkg holds the state enum (IDLE, RUN, FLUSH) and ASEL_INIT = 5'b00001.
- One sub-module, row_seq_counter, holds the col/row counter pair. It has increment, clear and wrap-at-WIDTH behaviour and a last-column flag. It is instantiated once and reused for the flush count.

## Test plan
All scenarios use WIDTH=8, HEIGHT=6.
- Reset, then 48 pixels with sof on the first (flush undefined):
  - asel sequence per line is 00001, 00010, 00100, 01000, 10000, 00001.
  - row advances every 8 beats.
  - eof is on beat 48.
- Same stimulus with ROW_BUFFER_SEQUENCER_FLUSH_EN:
  - 16 extra beats with ram_din=0 and ready=0.
  - win_valid is on cols 4-7 of rows 4-7, 16 beats total.
  - eof is on beat 64.
- Pixels with validin=1 but no sof while IDLE -> ram_ce stays 0 and col/row stay 0.
- sof re-asserted at row 2, col 3 -> the next output beat has col=0, row=0, asel=00001, and no eof pulse.
- validin toggled 1/0 every cycle in RUN -> ram_ce matches the accept pattern one cycle later, and col increments only on accepted beats.
- reset_n driven low for one cycle during row 3 -> all outputs at reset values the next cycle, and the block ignores pixels until the next sof.
